// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    // Controller states: CLEAR runs the init sweep, RUN is normal operation.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    // Sweep init value selection.
    localparam int RF_INIT_INDEX = 0;
    localparam int RF_INIT_ZERO  = 1;

endpackage

// File: rtl/regfile_clear_seq.sv
// Init-sweep controller: walks every entry once after reset, then enters RUN.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              in_run,
    output logic              busy
);

    rf_state_t         state;
    rf_state_t         next_state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] next_idx;

    // State, sweep index and busy flag; busy is registered from the next state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= RF_CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            busy  <= (next_state != RF_RUN);
        end
    end

    // Advance the sweep one entry per cycle; leave CLEAR after the last entry.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            RF_CLEAR: begin
                next_idx = idx + 1'b1;
                if (idx == {ADDR_W{1'b1}}) begin
                    next_state = RF_RUN;
                end
            end
            RF_RUN: begin
                next_state = RF_RUN;
            end
            default: begin
                next_state = RF_CLEAR;
                next_idx   = '0;
            end
        endcase
    end

    // Decode state into sweep write strobe, sweep address and run flag.
    always_comb begin
        sweep_we   = (state == RF_CLEAR);
        sweep_addr = idx;
        in_run     = (state == RF_RUN);
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD registered read ports, one write port,
// optional write-to-read bypass, optional hard-wired zero entry, debug port
// without bypass, and a hardware init sweep after reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              in_run;
    logic              wr_eff;
    logic [EXT_W-1:0]  idx_ext;
    logic [DATA_W-1:0] init_val;

    regfile_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .sweep_we  (sweep_we),
        .sweep_addr(sweep_addr),
        .in_run    (in_run),
        .busy      (busy)
    );

    // Index widened (or left wide) so it can be zero-extended or truncated to DATA_W.
    assign idx_ext = EXT_W'(sweep_addr);

    // Value written into each entry during the sweep.
    always_comb begin
        init_val = '0;
        if (INIT_MODE == RF_INIT_INDEX) begin
            init_val = idx_ext[DATA_W-1:0];
        end else if (INIT_MODE == RF_INIT_ZERO) begin
            init_val = '0;
        end
    end

    // An external write only counts in RUN and never lands on a protected entry 0.
    always_comb begin
        wr_eff = in_run && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    end

    // Array write: sweep has the port during CLEAR, writeback during RUN, nothing in reset.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (sweep_we) begin
                mem[sweep_addr] <= init_val;
            end else if (wr_eff) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // Debug read returns the pre-write contents; no bypass on this path.
    always_ff @(posedge clock) begin
        if (!reset_n || !in_run) begin
            dbg_data <= '0;
        end else if ((ZERO_REG != 0) && (dbg_addr == '0)) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= mem[dbg_addr];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rd_q;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // Per-port read: zero entry first, then bypass from the write port, else array.
        always_ff @(posedge clock) begin
            if (!reset_n || !in_run) begin
                rd_q <= '0;
            end else if ((ZERO_REG != 0) && (addr == '0)) begin
                rd_q <= '0;
            end else if ((BYPASS != 0) && wr_eff && (wr_addr == addr)) begin
                rd_q <= wr_data;
            end else begin
                rd_q <= mem[addr];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: three 32x32 variants share
// stimulus (default, no zero register, no bypass); a fourth small variant
// (16-bit, 8 entries, 4 read ports, zero init) has its own stimulus.
module tb_regfile_mp;

    logic        clock;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic [4:0]  dbg_addr;

    logic [63:0] rd_def, rd_nz, rd_nb;
    logic [31:0] dbg_def, dbg_nz, dbg_nb;
    logic        busy_def, busy_nz, busy_nb;

    logic        s_reset_n;
    logic        s_wr_en;
    logic [2:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic [11:0] s_rd_addr;
    logic [2:0]  s_dbg_addr;
    logic [63:0] s_rd_data;
    logic [15:0] s_dbg_data;
    logic        s_busy;

    int tests_run;
    int tests_failed;
    int cnt;

    regfile_mp u_def (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_def),
        .dbg_addr(dbg_addr), .dbg_data(dbg_def), .busy(busy_def)
    );

    regfile_mp #(.ZERO_REG(0)) u_nz (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_nz),
        .dbg_addr(dbg_addr), .dbg_data(dbg_nz), .busy(busy_nz)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_nb),
        .dbg_addr(dbg_addr), .dbg_data(dbg_nb), .busy(busy_nb)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .INIT_MODE(1)) u_small (
        .clock(clock), .reset_n(s_reset_n), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
        .wr_data(s_wr_data), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data), .busy(s_busy)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge and settle away from it.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed sequence.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        s_reset_n    = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        rd_addr      = '0;
        dbg_addr     = '0;
        s_wr_en      = 1'b0;
        s_wr_addr    = '0;
        s_wr_data    = '0;
        s_rd_addr    = '0;
        s_dbg_addr   = '0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("reset_busy", {63'd0, busy_def}, 64'd1);
        checkOutput("reset_rd", rd_def, 64'd0);
        checkOutput("reset_dbg", {32'd0, dbg_def}, 64'd0);

        // Release and measure sweep length.
        reset_n = 1'b1;
        cnt = 0;
        while (busy_def === 1'b1 && cnt < 100) begin
            applyStimulus();
            cnt++;
        end
        checkOutput("sweep_len", 64'(cnt), 64'd32);
        checkOutput("sweep_nb_busy", {63'd0, busy_nb}, 64'd0);

        // Swept contents equal index.
        rd_addr  = {5'd5, 5'd31};
        dbg_addr = 5'd17;
        applyStimulus();
        checkOutput("init_rd", rd_def, {32'd5, 32'd31});
        checkOutput("init_dbg", {32'd0, dbg_def}, 64'd17);

        // Zero register protection.
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'hDEADBEEF;
        applyStimulus();
        wr_en    = 1'b0;
        rd_addr  = {5'd0, 5'd0};
        dbg_addr = 5'd0;
        applyStimulus();
        checkOutput("zero_rd", rd_def, 64'd0);
        checkOutput("zero_dbg", {32'd0, dbg_def}, 64'd0);
        checkOutput("nozero_rd", rd_nz, {32'hDEADBEEF, 32'hDEADBEEF});
        checkOutput("nozero_dbg", {32'd0, dbg_nz}, {32'd0, 32'hDEADBEEF});

        // Same-cycle write and read of address 9.
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h12345678;
        rd_addr = {5'd9, 5'd9};
        applyStimulus();
        checkOutput("bypass_rd", rd_def, {32'h12345678, 32'h12345678});
        checkOutput("nobypass_rd", rd_nb, {32'd9, 32'd9});
        wr_en = 1'b0;
        applyStimulus();
        checkOutput("nobypass_next", rd_nb, {32'h12345678, 32'h12345678});

        // Debug port sees pre-write data on the write edge.
        wr_en    = 1'b1;
        wr_addr  = 5'd4;
        wr_data  = 32'hCAFEF00D;
        dbg_addr = 5'd4;
        applyStimulus();
        checkOutput("dbg_old", {32'd0, dbg_def}, 64'd4);
        wr_en = 1'b0;
        applyStimulus();
        checkOutput("dbg_new", {32'd0, dbg_def}, {32'd0, 32'hCAFEF00D});

        // Mid-sweep reset restarts the sweep; writes during it are dropped.
        reset_n = 1'b0;
        applyStimulus();
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) applyStimulus();
        reset_n = 1'b0;
        applyStimulus();
        reset_n = 1'b1;
        rd_addr = {5'd3, 5'd21};
        for (int k = 1; k <= 32; k++) begin
            wr_en   = (k == 15) || (k == 32);
            wr_addr = (k == 15) ? 5'd3 : 5'd21;
            wr_data = (k == 15) ? 32'h00000BAD : 32'h0000BAD2;
            applyStimulus();
            if (k == 16) checkOutput("sweep_rd_zero", rd_def, 64'd0);
            if (k >= 30) checkOutput($sformatf("resweep_busy_%0d", k), {63'd0, busy_def}, {63'd0, k < 32});
        end
        wr_en   = 1'b1;
        wr_addr = 5'd22;
        wr_data = 32'h00000055;
        applyStimulus();
        checkOutput("ignored_writes", rd_def, {32'd3, 32'd21});
        wr_en   = 1'b0;
        rd_addr = {5'd22, 5'd22};
        applyStimulus();
        checkOutput("first_write", rd_def, {32'h55, 32'h55});

        // Small configuration.
        s_reset_n = 1'b1;
        cnt = 0;
        while (s_busy === 1'b1 && cnt < 100) begin
            applyStimulus();
            cnt++;
        end
        checkOutput("small_sweep_len", 64'(cnt), 64'd8);
        s_wr_en   = 1'b1;
        s_wr_addr = 3'd7;
        s_wr_data = 16'hA5A5;
        applyStimulus();
        s_wr_en   = 1'b0;
        s_rd_addr = {3'd7, 3'd7, 3'd7, 3'd7};
        applyStimulus();
        checkOutput("small_rd7", s_rd_data, 64'hA5A5_A5A5_A5A5_A5A5);
        s_rd_addr  = {3'd3, 3'd3, 3'd3, 3'd3};
        s_dbg_addr = 3'd7;
        applyStimulus();
        checkOutput("small_rd3", s_rd_data, 64'd0);
        checkOutput("small_dbg7", {48'd0, s_dbg_data}, 64'hA5A5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
